pc_fetch_reg: RTL and testbench
===============================

Name: pc_fetch_reg

Overview:
- Program-counter register and IF/ID address latch for the P5 pipeline fetch stage.
- Consumes the sequential next-PC from the PC+4 incrementer and redirect targets from the branch/jump resolver in ID.
- Handles stalls, redirects that arrive during a stall (held pending), the delay-slot policy, and instruction-memory range faults.
- Drives the current PC back to the incrementer and instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address, inclusive.
- DELAY_SLOT, 1, 1 = the instruction fetched on a redirect cycle advances to IF/ID valid; 0 = it is squashed.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard stall from ID; hold PC and IF/ID
- seq_next  in  32  next sequential PC from the incrementer (PC+4)
- redirect  in  1  branch taken or jump, resolved in ID
- redirect_target  in  32  branch/jump destination
- pc  out  32  current fetch address, to IM and incrementer
- if_pc  out  32  PC of the instruction held in IF/ID
- if_valid  out  1  IF/ID holds a real instruction
- pending  out  1  a redirect is latched and waiting for stall release
- addr_fault  out  1  sticky: illegal fetch address was produced
- fetch_count  out  32  count of instructions accepted into IF/ID

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, if_pc=0, if_valid=0, pending=0, addr_fault=0, fetch_count=0.
  - Internal pending target cleared. State=RUN.
  - Reset mid-stall or mid-pending discards the pending redirect.
- States: RUN (pending=0) and PEND (pending=1). pending is the registered state bit.
- RUN, stall=0, redirect=0:
  - pc<=seq_next.
  - if_pc<=pc, if_valid<=1, fetch_count+1.
- RUN, stall=0, redirect=1:
  - pc<=redirect_target with bits[1:0] forced to 0.
  - if_pc<=pc.
  - DELAY_SLOT=1: if_valid<=1, fetch_count+1.
  - DELAY_SLOT=0: if_valid<=0, fetch_count unchanged.
- RUN, stall=1:
  - pc, if_pc, if_valid and fetch_count hold.
  - If redirect=1: latch the target and go to PEND.
- PEND, stall=1:
  - Everything holds.
  - A new redirect overwrites the pending target; the latest one wins.
- PEND, stall=0:
  - pc<=live redirect_target if redirect=1, else the pending target (bits[1:0] forced to 0).
  - IF/ID updates as in a RUN redirect cycle. Return to RUN.
- Faults (each sets addr_fault<=1; it stays set until reset):
  - Redirect target with nonzero bits[1:0].
  - Value loaded into pc outside [IM_BASE, IM_LIMIT].
  - Sequential overflow: seq_next > IM_LIMIT loads pc<=IM_BASE (wrap) and faults.
- Width rules:
  - All address arithmetic is 32-bit unsigned; the block performs no addition of its own.
  - fetch_count wraps modulo 2^32.
- Latency: every update takes effect on the clk edge after its inputs; there are no combinational paths from inputs to outputs.

Test Plan:
- Release reset, stall=0, seq_next driven as pc+4 for 3 cycles -> pc=3000, 3004, 3008, 300C; if_pc lags by 1 cycle; if_valid=1 from cycle 1; fetch_count=3.
- At pc=3008, redirect=1, target=0x3100, DELAY_SLOT=1 -> next pc=3100, if_pc=3008, if_valid=1; repeat with DELAY_SLOT=0 -> if_valid=0, fetch_count unchanged.
- stall=1 for 3 cycles at pc=3010, redirect=1 target 0x3200 in cycle 1, then 0x3300 in cycle 2 -> pc holds 3010, pending=1; on release pc=3300, pending=0.
- Redirect target 0x3102 -> pc=3100, addr_fault=1 and stays 1 through 10 further normal cycles.
- pc=IM_LIMIT (6FFC), seq_next=7000 -> pc=3000, addr_fault=1.
- Assert reset while pending=1 and stall=1 -> immediately pc=3000, pending=0, if_valid=0, fetch_count=0; after release, sequential fetch from 3000 with no stale redirect.

Source files
------------

// File: rtl/pc_fetch_reg.sv
// -----------------------------------------------------------------------------
// pc_fetch_reg
//   Program-counter register and IF/ID address latch for the P5 fetch stage.
//   Selects the next PC from the sequential incrementer or a branch/jump
//   redirect. A redirect that arrives while ID stalls is parked and applied
//   when the stall releases. Illegal fetch addresses raise a sticky fault.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-low reset
//   stall           in   hazard stall from ID; hold PC and IF/ID
//   seq_next        in   next sequential PC (PC+4) from the incrementer
//   redirect        in   branch taken / jump resolved in ID
//   redirect_target in   branch/jump destination
//   pc              out  current fetch address, to IM and the incrementer
//   if_pc           out  PC of the instruction held in IF/ID
//   if_valid        out  IF/ID holds a real instruction
//   pending         out  a redirect is parked waiting for stall release
//   addr_fault      out  sticky illegal-fetch-address flag
//   fetch_count     out  instructions accepted into IF/ID (wraps mod 2^32)
// -----------------------------------------------------------------------------
module pc_fetch_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] seq_next,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        pending,
  output logic        addr_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] if_pc_reg;
  logic        if_valid_reg;
  logic        addr_fault_reg;
  logic [31:0] fetch_count_reg;
  logic [31:0] pend_target_reg;

  // Word-aligned version of the live redirect target; the low two bits are
  // dropped before they ever reach pc or the pending-target register.
  logic [31:0] live_target;
  logic        misaligned;

  logic        advance;        // stall released: pc and IF/ID move this edge
  logic        take_redirect;  // the moving pc comes from a redirect
  logic [31:0] redir_pc;
  logic        seq_overflow;
  logic [31:0] pc_next;
  logic        out_of_range;
  logic        fault_next;
  logic        slot_valid;   // instruction entering IF/ID is real

  assign live_target = {redirect_target[31:2], 2'b00};
  assign misaligned  = redirect && (redirect_target[1:0] != 2'b00);

  assign advance       = !stall;
  assign take_redirect = redirect || (state_reg == PEND);
  // A live redirect on the release cycle is newer than the parked one.
  assign redir_pc      = redirect ? live_target : pend_target_reg;
  assign seq_overflow  = (seq_next > IM_LIMIT);

  always_comb begin
    pc_next = seq_next;
    if (take_redirect) begin
      pc_next = redir_pc;
    end else if (seq_overflow) begin
      // Running off the top of IM wraps back to the base of IM.
      pc_next = IM_BASE;
    end
  end

  assign out_of_range = (pc_next < IM_BASE) || (pc_next > IM_LIMIT);

  // A misaligned target is flagged whenever it is presented, including while
  // stalled (it is being captured as the pending target at that point).
  assign fault_next = misaligned ||
                      (advance && (out_of_range ||
                                   (!take_redirect && seq_overflow)));

  // With no delay slot, the instruction fetched alongside a redirect is
  // squashed rather than passed into IF/ID.
  assign slot_valid = !take_redirect || DELAY_SLOT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      if_pc_reg       <= 32'h0;
      if_valid_reg    <= 1'b0;
      addr_fault_reg  <= 1'b0;
      fetch_count_reg <= 32'h0;
      pend_target_reg <= 32'h0;
    end else begin
      if (fault_next) begin
        addr_fault_reg <= 1'b1;
      end

      if (advance) begin
        pc_reg       <= pc_next;
        if_pc_reg    <= pc_reg;
        if_valid_reg <= slot_valid;
        if (slot_valid) begin
          fetch_count_reg <= fetch_count_reg + 32'd1;
        end
        state_reg <= RUN;
      end else if (redirect) begin
        // Latest redirect during a stall wins; earlier ones are overwritten.
        pend_target_reg <= live_target;
        state_reg       <= PEND;
      end
    end
  end

  assign pc          = pc_reg;
  assign if_pc       = if_pc_reg;
  assign if_valid    = if_valid_reg;
  assign pending     = (state_reg == PEND);
  assign addr_fault  = addr_fault_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_reg
//   Two instances (delay slot on / off) share every input. Directed vectors
//   from a table, hand-written reset and boundary sequences, then random
//   stimulus checked against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_pc_fetch_reg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] seq_next;
  logic [31:0] redirect_target;

  logic [31:0] pc_a, pc_b, if_pc_a, if_pc_b, fc_a, fc_b;
  logic        v_a, v_b, pend_a, pend_b, flt_a, flt_b;

  pc_fetch_reg #(.RESET_PC(RESET_PC), .IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT),
                 .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset(reset), .stall(stall), .seq_next(seq_next),
    .redirect(redirect), .redirect_target(redirect_target),
    .pc(pc_a), .if_pc(if_pc_a), .if_valid(v_a), .pending(pend_a),
    .addr_fault(flt_a), .fetch_count(fc_a)
  );

  pc_fetch_reg #(.RESET_PC(RESET_PC), .IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT),
                 .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset(reset), .stall(stall), .seq_next(seq_next),
    .redirect(redirect), .redirect_target(redirect_target),
    .pc(pc_b), .if_pc(if_pc_b), .if_valid(v_b), .pending(pend_b),
    .addr_fault(flt_b), .fetch_count(fc_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ifpc, m_fc1, m_fc0, m_tgt;
  logic        m_v1, m_v0;
  bit          m_pend, m_fault;

  task automatic model_reset();
    m_pc = RESET_PC; m_ifpc = 32'h0; m_v1 = 1'b0; m_v0 = 1'b0;
    m_fc1 = 32'h0; m_fc0 = 32'h0; m_pend = 1'b0; m_tgt = 32'h0; m_fault = 1'b0;
  endtask

  // State after one clock with the given inputs.
  task automatic model_step(input logic st, input logic rd,
                            input logic [31:0] tgt, input logic [31:0] sq);
    bit          jump;
    logic [31:0] dest;
    if (rd && (tgt % 4 != 0)) m_fault = 1'b1;
    if (st) begin
      if (rd) begin
        m_pend = 1'b1;
        m_tgt  = tgt - (tgt % 4);
      end
    end else begin
      jump = rd || m_pend;
      if (rd)               dest = tgt - (tgt % 4);
      else if (m_pend)      dest = m_tgt;
      else if (sq > IM_LIMIT) begin
        dest    = IM_BASE;
        m_fault = 1'b1;
      end else              dest = sq;
      if (dest < IM_BASE || dest > IM_LIMIT) m_fault = 1'b1;
      m_ifpc = m_pc;
      m_pc   = dest;
      m_v1   = 1'b1;
      m_v0   = !jump;
      m_fc1  = m_fc1 + 1;
      if (!jump) m_fc0 = m_fc0 + 1;
      m_pend = 1'b0;
    end
  endtask

  task automatic drive_cycle(input logic st, input logic rd,
                             input logic [31:0] tgt, input logic [31:0] sq);
    stall = st; redirect = rd; redirect_target = tgt; seq_next = sq;
    model_step(st, rd, tgt, sq);
    @(posedge clk);
    #1;
    $display("cyc st=%0b rd=%0b tgt=%h seq=%h -> pc=%h if_pc=%h v=%0b/%0b pend=%0b flt=%0b fc=%0d/%0d",
             st, rd, tgt, sq, pc_a, if_pc_a, v_a, v_b, pend_a, flt_a, fc_a, fc_b);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc1"},    pc_a,    m_pc);
    chk({tag, ".pc0"},    pc_b,    m_pc);
    chk({tag, ".if_pc1"}, if_pc_a, m_ifpc);
    chk({tag, ".if_pc0"}, if_pc_b, m_ifpc);
    chk({tag, ".v1"},     {31'b0, v_a},    {31'b0, m_v1});
    chk({tag, ".v0"},     {31'b0, v_b},    {31'b0, m_v0});
    chk({tag, ".pend1"},  {31'b0, pend_a}, {31'b0, m_pend});
    chk({tag, ".pend0"},  {31'b0, pend_b}, {31'b0, m_pend});
    chk({tag, ".flt1"},   {31'b0, flt_a},  {31'b0, m_fault});
    chk({tag, ".flt0"},   {31'b0, flt_b},  {31'b0, m_fault});
    chk({tag, ".fc1"},    fc_a,    m_fc1);
    chk({tag, ".fc0"},    fc_b,    m_fc0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from the clock edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model({tag, ".in_reset"});
    stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; seq_next = RESET_PC + 4;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        st, rd;
    logic [31:0] tgt, sq, pc, ifpc;
    logic        v1, v0, pend, flt;
    logic [31:0] fc1, fc0;
  } vec_t;

  function automatic vec_t mk(logic st, logic rd, logic [31:0] tgt, logic [31:0] sq,
                              logic [31:0] pc, logic [31:0] ifpc, logic v1, logic v0,
                              logic pend, logic flt, logic [31:0] fc1, logic [31:0] fc0);
    vec_t v;
    v.st = st; v.rd = rd; v.tgt = tgt; v.sq = sq; v.pc = pc; v.ifpc = ifpc;
    v.v1 = v1; v.v0 = v0; v.pend = pend; v.flt = flt; v.fc1 = fc1; v.fc0 = fc0;
    return v;
  endfunction

  vec_t vt[13];

  initial begin
    logic [31:0] t, s;
    bit          st_r, rd_r;

    vt[0]  = mk(0, 0, 32'h0,    32'h3004, 32'h3004, 32'h3000, 1, 1, 0, 0, 1, 1);
    vt[1]  = mk(0, 0, 32'h0,    32'h3008, 32'h3008, 32'h3004, 1, 1, 0, 0, 2, 2);
    vt[2]  = mk(0, 0, 32'h0,    32'h300C, 32'h300C, 32'h3008, 1, 1, 0, 0, 3, 3);
    vt[3]  = mk(0, 1, 32'h3008, 32'h3010, 32'h3008, 32'h300C, 1, 0, 0, 0, 4, 3);
    vt[4]  = mk(0, 1, 32'h3100, 32'h300C, 32'h3100, 32'h3008, 1, 0, 0, 0, 5, 3);
    vt[5]  = mk(0, 0, 32'h0,    32'h3104, 32'h3104, 32'h3100, 1, 1, 0, 0, 6, 4);
    vt[6]  = mk(0, 1, 32'h3010, 32'h3108, 32'h3010, 32'h3104, 1, 0, 0, 0, 7, 4);
    vt[7]  = mk(1, 1, 32'h3200, 32'h3014, 32'h3010, 32'h3104, 1, 0, 1, 0, 7, 4);
    vt[8]  = mk(1, 1, 32'h3300, 32'h3014, 32'h3010, 32'h3104, 1, 0, 1, 0, 7, 4);
    vt[9]  = mk(1, 0, 32'h0,    32'h3014, 32'h3010, 32'h3104, 1, 0, 1, 0, 7, 4);
    vt[10] = mk(0, 0, 32'h0,    32'h3014, 32'h3300, 32'h3010, 1, 0, 0, 0, 8, 4);
    vt[11] = mk(0, 0, 32'h0,    32'h3304, 32'h3304, 32'h3300, 1, 1, 0, 0, 9, 5);
    vt[12] = mk(0, 1, 32'h3102, 32'h3308, 32'h3100, 32'h3304, 1, 0, 0, 1, 10, 5);

    reset = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirect_target = 32'h0; seq_next = 32'h0;
    #1 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    seq_next = RESET_PC + 4;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // The edge right after release must not move the bench's expectations:
    // inputs were held at seq 3004, so step the model for that edge.
    model_step(1'b0, 1'b0, 32'h0, RESET_PC + 4);
    check_model("release");
    // Restart the table from a clean reset state.
    pulse_reset("pre_table");
    model_step(1'b0, 1'b0, 32'h0, RESET_PC + 4);
    pulse_reset("pre_table2");
    model_reset();
    // pulse_reset leaves one clock after release with seq=3004 applied; undo
    // by a fresh asynchronous reset held across no edge.
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    stall = 1'b0; redirect = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive_cycle(vt[i].st, vt[i].rd, vt[i].tgt, vt[i].sq);
      chk($sformatf("vec%0d.pc1", i),   pc_a,    vt[i].pc);
      chk($sformatf("vec%0d.pc0", i),   pc_b,    vt[i].pc);
      chk($sformatf("vec%0d.if_pc", i), if_pc_a, vt[i].ifpc);
      chk($sformatf("vec%0d.v1", i),    {31'b0, v_a},    {31'b0, vt[i].v1});
      chk($sformatf("vec%0d.v0", i),    {31'b0, v_b},    {31'b0, vt[i].v0});
      chk($sformatf("vec%0d.pend", i),  {31'b0, pend_a}, {31'b0, vt[i].pend});
      chk($sformatf("vec%0d.flt", i),   {31'b0, flt_a},  {31'b0, vt[i].flt});
      chk($sformatf("vec%0d.fc1", i),   fc_a,    vt[i].fc1);
      chk($sformatf("vec%0d.fc0", i),   fc_b,    vt[i].fc0);
    end

    // Fault stays set through ten ordinary cycles.
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, m_pc + 4);
      chk($sformatf("sticky%0d", i), {31'b0, flt_a}, 32'h1);
      check_model("sticky");
    end

    // Reset while stalled with a redirect parked: nothing stale survives.
    drive_cycle(1'b1, 1'b1, 32'h3500, m_pc + 4);
    chk("parked.pend", {31'b0, pend_a}, 32'h1);
    stall = 1'b1; redirect = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async.pc",   pc_a, 32'h3000);
    chk("async.pend", {31'b0, pend_a}, 32'h0);
    chk("async.v",    {31'b0, v_a},    32'h0);
    chk("async.fc",   fc_a, 32'h0);
    chk("async.flt",  {31'b0, flt_a},  32'h0);
    stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0, m_pc + 4);
      chk($sformatf("post_rst%0d.pc", i), pc_a, RESET_PC + 32'(4 * (i + 1)));
      check_model("post_rst");
    end

    // Top-of-IM boundary: IM_LIMIT itself is legal, the next step wraps.
    drive_cycle(1'b0, 1'b1, IM_LIMIT, m_pc + 4);
    chk("limit.pc",  pc_a, 32'h6FFC);
    chk("limit.flt", {31'b0, flt_a}, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 32'h7000);
    chk("wrap.pc",  pc_a, 32'h3000);
    chk("wrap.flt", {31'b0, flt_a}, 32'h1);
    check_model("wrap");

    // Redirect just below IM_BASE is loaded but faults.
    pulse_reset("below");
    model_step(1'b0, 1'b0, 32'h0, RESET_PC + 4);
    drive_cycle(1'b0, 1'b1, 32'h2FFC, m_pc + 4);
    chk("below.pc",  pc_a, 32'h2FFC);
    chk("below.flt", {31'b0, flt_a}, 32'h1);
    check_model("below");

    // Random stimulus against the model, with periodic resets.
    pulse_reset("rand");
    model_step(1'b0, 1'b0, 32'h0, RESET_PC + 4);
    check_model("rand_start");
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) begin
        pulse_reset("rand_rst");
        model_step(1'b0, 1'b0, 32'h0, RESET_PC + 4);
        check_model("rand_rst_after");
      end
      st_r = ($urandom_range(0, 9) < 3);
      rd_r = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 49) == 0) t = $urandom();
      else                            t = IM_BASE + ($urandom_range(0, 4095) << 2);
      if ($urandom_range(0, 9) == 0)  s = IM_BASE + ($urandom_range(0, 4096) << 2);
      else                            s = m_pc + 4;
      drive_cycle(st_r, rd_r, t, s);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
